gcc_centroid_smoother: RTL and testbench

//  Downstream stage of the gravity-center calculator (GCC). Captures each Xc/Yc result on the
//  GCC's active-low READY_ strobe and keeps a sliding window of the last 2**LOG2_WIN results.

---
 rtl/gcc_centroid_smoother.sv | 153 +++++++++++++++
 tb/tb_gcc_centroid_smoother.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/gcc_centroid_smoother.sv
// Sliding-window moving average of GCC centroid results, published over VALID/ACCEPT.
// Optional jump detection on the published stream is enabled with `define JUMP_DETECT_EN.
module gcc_centroid_smoother #(
  parameter int LOG2_WIN = 2
`ifdef JUMP_DETECT_EN
  ,
  parameter int JUMP_THR = 16
`endif
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] Xc,
  input  logic [7:0] Yc,
  input  logic       READY_,
  input  logic       FLUSH,
  input  logic       ACCEPT,
  output logic [7:0] Xa,
  output logic [7:0] Ya,
  output logic       VALID,
  output logic [7:0] DROP_CNT
`ifdef JUMP_DETECT_EN
  ,
  output logic       JUMP
`endif
);

  localparam int DATA_W = 8;
  localparam int WIN    = 2 ** LOG2_WIN;
  localparam int SUM_W  = DATA_W + LOG2_WIN;
  localparam logic [LOG2_WIN-1:0] LAST = LOG2_WIN'(WIN - 1);

  typedef enum logic {FILL, RUN} state_t;

  state_t              state, state_nxt;
  logic [LOG2_WIN-1:0] wptr_p1;
  logic [SUM_W-1:0]    sum_x_p1, sum_y_p1;
  logic [SUM_W-1:0]    old_x, old_y;
  logic                vld_p1;
  logic                sample;
  logic [DATA_W-1:0]   win_x [WIN];
  logic [DATA_W-1:0]   win_y [WIN];

  function automatic logic [DATA_W-1:0] round_avg(input logic [SUM_W-1:0] s);
    logic [SUM_W:0] t;
    t = {1'b0, s} + (SUM_W + 1)'(WIN / 2);
    return DATA_W'(t >> LOG2_WIN);
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  assign sample = !READY_ && !FLUSH;

  always_comb begin
    state_nxt = state;
    if (FLUSH)
      state_nxt = FILL;
    else if (!READY_ && state == FILL && wptr_p1 == LAST)
      state_nxt = RUN;
  end

  always_ff @(posedge CLK) begin
    if (RESET) state <= FILL;
    else       state <= state_nxt;
  end

  // While filling, the slot being written holds no window member yet.
  always_comb begin
    old_x = '0;
    old_y = '0;
    if (state == RUN) begin
      old_x = SUM_W'(win_x[wptr_p1]);
      old_y = SUM_W'(win_y[wptr_p1]);
    end
  end

  // Stage 1: window update; in FILL the write pointer doubles as the fill count
  always_ff @(posedge CLK) begin
    if (RESET || FLUSH) begin
      wptr_p1  <= '0;
      sum_x_p1 <= '0;
      sum_y_p1 <= '0;
      vld_p1   <= 1'b0;
    end else begin
      vld_p1 <= 1'b0;
      if (!READY_) begin
        sum_x_p1 <= sum_x_p1 + SUM_W'(Xc) - old_x;
        sum_y_p1 <= sum_y_p1 + SUM_W'(Yc) - old_y;
        wptr_p1  <= wptr_p1 + LOG2_WIN'(1);
        vld_p1   <= (state == RUN) || (wptr_p1 == LAST);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (sample) begin
      win_x[wptr_p1] <= Xc;
      win_y[wptr_p1] <= Yc;
    end
  end

  // Stage 2: rounded average and output handshake
  always_ff @(posedge CLK) begin
    if (RESET) begin
      Xa       <= '0;
      Ya       <= '0;
      VALID    <= 1'b0;
      DROP_CNT <= '0;
    end else if (FLUSH) begin
      VALID <= 1'b0;
    end else if (vld_p1) begin
      Xa    <= round_avg(sum_x_p1);
      Ya    <= round_avg(sum_y_p1);
      VALID <= 1'b1;
      if (VALID && !ACCEPT) DROP_CNT <= sat_inc(DROP_CNT);
    end else if (VALID && ACCEPT) begin
      VALID <= 1'b0;
    end
  end

`ifdef JUMP_DETECT_EN
  logic [DATA_W-1:0] xc_p1, yc_p1;
  logic              pub_vld;

  function automatic logic [DATA_W-1:0] abs_diff(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    return (a > b) ? a - b : b - a;
  endfunction

  always_ff @(posedge CLK) begin
    if (sample) begin
      xc_p1 <= Xc;
      yc_p1 <= Yc;
    end
  end

  // Xa/Ya already hold the last published average; pub_vld marks it as meaningful.
  always_ff @(posedge CLK) begin
    if (RESET || FLUSH) begin
      JUMP    <= 1'b0;
      pub_vld <= 1'b0;
    end else if (vld_p1) begin
      JUMP    <= pub_vld && ((int'(abs_diff(xc_p1, Xa)) > JUMP_THR) ||
                             (int'(abs_diff(yc_p1, Ya)) > JUMP_THR));
      pub_vld <= 1'b1;
    end else if (VALID && ACCEPT) begin
      JUMP <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_gcc_centroid_smoother.sv
// Bench for gcc_centroid_smoother: directed scenarios plus random traffic against a window model.
module tb_gcc_centroid_smoother;
  localparam int WIN      = 4;
  localparam int JUMP_THR = 16;

  logic       CLK = 1'b0;
  logic       RESET, READY_, FLUSH, ACCEPT;
  logic [7:0] Xc, Yc, Xa, Ya, DROP_CNT;
  logic       VALID;
`ifdef JUMP_DETECT_EN
  logic       JUMP;
`endif

  gcc_centroid_smoother dut (
    .CLK(CLK), .RESET(RESET), .Xc(Xc), .Yc(Yc), .READY_(READY_), .FLUSH(FLUSH),
    .ACCEPT(ACCEPT), .Xa(Xa), .Ya(Ya), .VALID(VALID), .DROP_CNT(DROP_CNT)
`ifdef JUMP_DETECT_EN
    , .JUMP(JUMP)
`endif
  );

  always #5 CLK = ~CLK;

  int    checks = 0, failures = 0;
  string tag = "reset";
  int    qx[$], qy[$];
  int    m_valid, m_xa, m_ya, m_drop, m_pend, m_px, m_py, m_rx, m_ry, m_jump, m_lastv;

  function automatic int absd(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s.%s observed=%0d expected=%0d", tag, name, obs, exp);
    end
  endtask

  task automatic model_reset();
    qx.delete(); qy.delete();
    m_valid = 0; m_xa = 0; m_ya = 0; m_drop = 0; m_pend = 0;
    m_px = 0; m_py = 0; m_rx = 0; m_ry = 0; m_jump = 0; m_lastv = 0;
  endtask

  // Behaviour at one clock edge, expressed as a window of the most recent samples.
  task automatic model_edge(input logic rdy_n, input int x, input int y,
                            input logic fl, input logic acc);
    int sx, sy;
    if (fl) begin
      qx.delete(); qy.delete();
      m_pend = 0; m_valid = 0; m_jump = 0; m_lastv = 0;
    end else begin
      if (m_pend != 0) begin
        if (m_valid != 0 && !acc) m_drop = (m_drop == 255) ? 255 : m_drop + 1;
        m_jump  = (m_lastv != 0) && (absd(m_rx, m_xa) > JUMP_THR || absd(m_ry, m_ya) > JUMP_THR);
        m_lastv = 1;
        m_xa = m_px; m_ya = m_py; m_valid = 1;
      end else if (m_valid != 0 && acc) begin
        m_valid = 0; m_jump = 0;
      end
      m_pend = 0;
      if (!rdy_n) begin
        qx.push_back(x); qy.push_back(y);
        if (qx.size() > WIN) begin
          void'(qx.pop_front()); void'(qy.pop_front());
        end
        if (qx.size() == WIN) begin
          sx = 0; sy = 0;
          foreach (qx[i]) begin sx += qx[i]; sy += qy[i]; end
          m_px = (sx + WIN / 2) / WIN;
          m_py = (sy + WIN / 2) / WIN;
          m_rx = x; m_ry = y;
          m_pend = 1;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("valid", VALID, m_valid);
    chk("xa", Xa, m_xa);
    chk("ya", Ya, m_ya);
    chk("drop", DROP_CNT, m_drop);
`ifdef JUMP_DETECT_EN
    chk("jump", JUMP, m_jump);
`endif
  endtask

  task automatic cyc(input logic rdy_n, input logic [7:0] x, input logic [7:0] y,
                     input logic fl, input logic acc);
    READY_ = rdy_n; Xc = x; Yc = y; FLUSH = fl; ACCEPT = acc;
    @(posedge CLK);
    model_edge(rdy_n, x, y, fl, acc);
    @(negedge CLK);
    check_all();
  endtask

  task automatic rst_cyc(input logic rdy_n);
    RESET = 1'b1; READY_ = rdy_n; Xc = 8'd99; Yc = 8'd99;
    @(posedge CLK);
    model_reset();
    @(negedge CLK);
    RESET = 1'b0;
    check_all();
  endtask

  initial begin
    RESET = 1'b1; READY_ = 1'b1; FLUSH = 1'b0; ACCEPT = 1'b1; Xc = '0; Yc = '0;
    model_reset();
    @(negedge CLK);
    rst_cyc(1'b1);
    rst_cyc(1'b1);
    chk("rst_valid", VALID, 0);
    chk("rst_drop", DROP_CNT, 0);

    tag = "fill";
    cyc(1'b0, 8'd10, 8'd20, 1'b0, 1'b1);
    cyc(1'b0, 8'd20, 8'd40, 1'b0, 1'b1);
    cyc(1'b0, 8'd30, 8'd60, 1'b0, 1'b1);
    cyc(1'b0, 8'd40, 8'd80, 1'b0, 1'b1);
    chk("no_valid_yet", VALID, 0);
    cyc(1'b1, 8'd0, 8'd0, 1'b0, 1'b1);
    chk("first_valid", VALID, 1);
    chk("first_xa", Xa, 25);
    chk("first_ya", Ya, 50);

    tag = "wrap";
    cyc(1'b0, 8'd50, 8'd100, 1'b0, 1'b1);
    cyc(1'b1, 8'd0, 8'd0, 1'b0, 1'b1);
    chk("wrap_xa", Xa, 35);
    chk("wrap_ya", Ya, 70);

    tag = "backpressure";
    cyc(1'b1, 8'd0, 8'd0, 1'b0, 1'b1);
    cyc(1'b0, 8'd60, 8'd120, 1'b0, 1'b0);
    cyc(1'b1, 8'd0, 8'd0, 1'b0, 1'b0);
    cyc(1'b0, 8'd70, 8'd140, 1'b0, 1'b0);
    cyc(1'b1, 8'd0, 8'd0, 1'b0, 1'b0);
    chk("bp_xa", Xa, 55);
    chk("bp_ya", Ya, 110);
    chk("bp_drop", DROP_CNT, 1);
    cyc(1'b1, 8'd0, 8'd0, 1'b0, 1'b0);
    chk("bp_hold", Xa, 55);
    cyc(1'b1, 8'd0, 8'd0, 1'b0, 1'b1);
    chk("bp_transfer", VALID, 0);

    tag = "saturate";
    for (int i = 0; i < 300; i++) cyc(1'b0, 8'd255, 8'd255, 1'b0, 1'b0);
    cyc(1'b1, 8'd0, 8'd0, 1'b0, 1'b0);
    chk("sat_xa", Xa, 255);
    chk("sat_ya", Ya, 255);
    chk("sat_drop", DROP_CNT, 255);

    tag = "mid_reset";
    cyc(1'b0, 8'd1, 8'd2, 1'b0, 1'b0);
    rst_cyc(1'b0);
    chk("mr_drop", DROP_CNT, 0);
    chk("mr_xa", Xa, 0);

    tag = "flush";
    for (int i = 1; i <= 6; i++) cyc(1'b0, 8'(i * 11), 8'(i * 7), 1'b0, 1'b0);
    chk("pre_flush_drop", DROP_CNT, 1);
    cyc(1'b0, 8'd200, 8'd200, 1'b1, 1'b0);
    chk("flush_valid", VALID, 0);
    chk("flush_drop", DROP_CNT, 1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'd80, 8'd40, 1'b0, 1'b1);
    cyc(1'b1, 8'd0, 8'd0, 1'b0, 1'b1);
    chk("refill_quiet", VALID, 0);
    cyc(1'b0, 8'd84, 8'd44, 1'b0, 1'b1);
    cyc(1'b1, 8'd0, 8'd0, 1'b0, 1'b1);
    chk("refill_valid", VALID, 1);
    chk("refill_xa", Xa, 81);
    chk("refill_ya", Ya, 41);

    tag = "random";
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
          ($urandom_range(0, 31) == 0), 1'($urandom_range(0, 1)));

`ifdef JUMP_DETECT_EN
    tag = "jump";
    rst_cyc(1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 8'd100, 8'd100, 1'b0, 1'b1);
    cyc(1'b1, 8'd0, 8'd0, 1'b0, 1'b1);
    chk("j_first", JUMP, 0);
    cyc(1'b1, 8'd0, 8'd0, 1'b0, 1'b1);
    cyc(1'b0, 8'd130, 8'd100, 1'b0, 1'b1);
    cyc(1'b1, 8'd0, 8'd0, 1'b0, 1'b1);
    chk("j_big", JUMP, 1);
    chk("j_big_xa", Xa, 108);
    cyc(1'b0, 8'd110, 8'd100, 1'b0, 1'b1);
    cyc(1'b1, 8'd0, 8'd0, 1'b0, 1'b1);
    chk("j_small", JUMP, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
